// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I subset (R/I ALU, load, store, branch).
// Sequences the shared datapath one state per cycle with a timed memory handshake.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TO_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] imm_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_we_cond,
    output logic       pc_src,
    output logic       reg_we,
    output logic       wb_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       mdr_we,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_ALU_WB   = 4'd10
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t          state_q;
    state_t          state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_nxt;
    logic            timeout_c;

    assign state = state_q;

    // State and timeout counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            to_cnt  <= '0;
        end else begin
            state_q <= state_nxt;
            to_cnt  <= to_cnt_nxt;
        end
    end

    // Last permitted wait cycle with no completion
    assign timeout_c = (to_cnt == TO_W'(TIMEOUT - 1)) && !mem_ready;

    // Next state and datapath controls; counter stays zero outside memory waits
    always_comb begin
        state_nxt  = state_q;
        to_cnt_nxt = '0;
        imm_sel    = 2'b11;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_we_cond = 1'b0;
        pc_src     = 1'b0;
        reg_we     = 1'b0;
        wb_sel     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        mdr_we     = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;

        case (state_q)
            S_IDLE: state_nxt = S_FETCH;

            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    state_nxt = S_DECODE;
                end else if (timeout_c) begin
                    bus_err   = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end

            // ALU precomputes the branch target into ALUOut
            S_DECODE: begin
                alu_src_b = 2'b10;
                imm_sel   = 2'b10;
                case (opcode)
                    OP_R:               state_nxt = S_EXEC_R;
                    OP_I:               state_nxt = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_nxt = S_MEM_ADDR;
                    OP_BRANCH:          state_nxt = S_BRANCH;
                    default: begin
                        illegal   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end

            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_nxt = S_ALU_WB;
            end

            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                imm_sel   = 2'b00;
                alu_op    = 2'b10;
                state_nxt = S_ALU_WB;
            end

            S_ALU_WB: begin
                reg_we    = 1'b1;
                state_nxt = S_FETCH;
            end

            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_STORE) begin
                    imm_sel   = 2'b01;
                    state_nxt = S_MEM_WR;
                end else begin
                    imm_sel   = 2'b00;
                    state_nxt = S_MEM_RD;
                end
            end

            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    mdr_we    = 1'b1;
                    state_nxt = S_MEM_WB;
                end else if (timeout_c) begin
                    bus_err   = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end

            S_MEM_WB: begin
                reg_we    = 1'b1;
                wb_sel    = 1'b1;
                state_nxt = S_FETCH;
            end

            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                imm_sel = 2'b01;
                if (mem_ready) begin
                    state_nxt = S_FETCH;
                end else if (timeout_c) begin
                    bus_err   = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end

            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_we_cond = 1'b1;
                pc_src     = 1'b1;
                state_nxt  = S_FETCH;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (TIMEOUT=4): per-cycle state and control word.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic [1:0] imm_sel;
    logic       ir_we, pc_we, pc_we_cond, pc_src, reg_we, wb_sel, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       mem_req, mem_we, iord, mdr_we, illegal, bus_err;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl #(.TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .imm_sel(imm_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_we_cond(pc_we_cond),
        .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .mdr_we(mdr_we), .illegal(illegal), .bus_err(bus_err),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word layout: imm_sel[18:17] ir_we pc_we pc_we_cond pc_src reg_we wb_sel
    // alu_src_a alu_src_b[9:8] alu_op[7:6] mem_req mem_we iord mdr_we illegal bus_err
    logic [18:0] cw;
    assign cw = {imm_sel, ir_we, pc_we, pc_we_cond, pc_src, reg_we, wb_sel, alu_src_a,
                 alu_src_b, alu_op, mem_req, mem_we, iord, mdr_we, illegal, bus_err};

    localparam logic [18:0] IM0 = 19'h00000;
    localparam logic [18:0] IM1 = 19'h20000;
    localparam logic [18:0] IM2 = 19'h40000;
    localparam logic [18:0] IM3 = 19'h60000;
    localparam logic [18:0] IRWE = 19'(1) << 16;
    localparam logic [18:0] PCWE = 19'(1) << 15;
    localparam logic [18:0] PCWC = 19'(1) << 14;
    localparam logic [18:0] PCSR = 19'(1) << 13;
    localparam logic [18:0] RGWE = 19'(1) << 12;
    localparam logic [18:0] WBS  = 19'(1) << 11;
    localparam logic [18:0] SRCA = 19'(1) << 10;
    localparam logic [18:0] B4   = 19'(1) << 8;
    localparam logic [18:0] BIMM = 19'(2) << 8;
    localparam logic [18:0] OSUB = 19'(1) << 6;
    localparam logic [18:0] OFN  = 19'(2) << 6;
    localparam logic [18:0] REQ  = 19'(1) << 5;
    localparam logic [18:0] MWE  = 19'(1) << 4;
    localparam logic [18:0] IORD = 19'(1) << 3;
    localparam logic [18:0] MDRW = 19'(1) << 2;
    localparam logic [18:0] ILL  = 19'(1) << 1;
    localparam logic [18:0] BERR = 19'(1);

    localparam logic [18:0] W_IDLE  = IM3;
    localparam logic [18:0] W_FW    = IM3 | REQ | B4;
    localparam logic [18:0] W_FR    = W_FW | IRWE | PCWE;
    localparam logic [18:0] W_DEC   = IM2 | BIMM;
    localparam logic [18:0] W_EXR   = IM3 | SRCA | OFN;
    localparam logic [18:0] W_EXI   = IM0 | SRCA | BIMM | OFN;
    localparam logic [18:0] W_AWB   = IM3 | RGWE;
    localparam logic [18:0] W_MAL   = IM0 | SRCA | BIMM;
    localparam logic [18:0] W_MAS   = IM1 | SRCA | BIMM;
    localparam logic [18:0] W_RDW   = IM3 | REQ | IORD;
    localparam logic [18:0] W_MWB   = IM3 | RGWE | WBS;
    localparam logic [18:0] W_WRW   = IM1 | REQ | MWE | IORD;
    localparam logic [18:0] W_BR    = IM3 | SRCA | OSUB | PCWC | PCSR;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%05h expected=%05h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, check state and controls mid-cycle, advance past the edge
    task automatic cyc(input logic rdy, input logic [6:0] op, input logic [3:0] es,
                       input logic [18:0] ew, input string tag);
        mem_ready = rdy;
        opcode    = op;
        #3;
        chk({tag, "_state"}, 19'(state), 19'(es));
        chk({tag, "_ctrl"}, cw, ew);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 7'd0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 7'd0, 4'd0, W_IDLE, "rst0");
        rst_n = 1'b1;
        cyc(1'b0, 7'd0, 4'd0, W_IDLE, "idle");

        // R-type, zero wait
        cyc(1'b1, OP_R, 4'd1, W_FR, "r_fetch");
        cyc(1'b1, OP_R, 4'd2, W_DEC, "r_dec");
        cyc(1'b1, OP_R, 4'd3, W_EXR, "r_exec");
        cyc(1'b1, OP_R, 4'd10, W_AWB, "r_wb");

        // I-type
        cyc(1'b1, OP_I, 4'd1, W_FR, "i_fetch");
        cyc(1'b0, OP_I, 4'd2, W_DEC, "i_dec");
        cyc(1'b0, OP_I, 4'd4, W_EXI, "i_exec");
        cyc(1'b0, OP_I, 4'd10, W_AWB, "i_wb");

        // Load with three wait cycles in MEM_RD
        cyc(1'b1, OP_LD, 4'd1, W_FR, "ld_fetch");
        cyc(1'b0, OP_LD, 4'd2, W_DEC, "ld_dec");
        cyc(1'b0, OP_LD, 4'd5, W_MAL, "ld_addr");
        cyc(1'b0, OP_LD, 4'd6, W_RDW, "ld_rd0");
        cyc(1'b0, OP_LD, 4'd6, W_RDW, "ld_rd1");
        cyc(1'b0, OP_LD, 4'd6, W_RDW, "ld_rd2");
        cyc(1'b1, OP_LD, 4'd6, W_RDW | MDRW, "ld_rd3");
        cyc(1'b0, OP_LD, 4'd7, W_MWB, "ld_wb");

        // Store
        cyc(1'b1, OP_ST, 4'd1, W_FR, "st_fetch");
        cyc(1'b0, OP_ST, 4'd2, W_DEC, "st_dec");
        cyc(1'b0, OP_ST, 4'd5, W_MAS, "st_addr");
        cyc(1'b1, OP_ST, 4'd8, W_WRW, "st_wr");

        // Branch
        cyc(1'b1, OP_BR, 4'd1, W_FR, "br_fetch");
        cyc(1'b0, OP_BR, 4'd2, W_DEC, "br_dec");
        cyc(1'b0, OP_BR, 4'd9, W_BR, "br_exec");

        // Illegal opcode
        cyc(1'b1, OP_BAD, 4'd1, W_FR, "ill_fetch");
        cyc(1'b0, OP_BAD, 4'd2, W_DEC | ILL, "ill_dec");

        // FETCH timeout, then completion exactly on the last allowed cycle
        cyc(1'b0, OP_R, 4'd1, W_FW, "fto_w0");
        cyc(1'b0, OP_R, 4'd1, W_FW, "fto_w1");
        cyc(1'b0, OP_R, 4'd1, W_FW, "fto_w2");
        cyc(1'b0, OP_R, 4'd1, W_FW | BERR, "fto_err");
        cyc(1'b0, OP_R, 4'd1, W_FW, "fto_r0");
        cyc(1'b0, OP_R, 4'd1, W_FW, "fto_r1");
        cyc(1'b0, OP_R, 4'd1, W_FW, "fto_r2");
        cyc(1'b1, OP_R, 4'd1, W_FR, "fto_rdy");
        cyc(1'b0, OP_R, 4'd2, W_DEC, "fto_dec");
        cyc(1'b0, OP_R, 4'd3, W_EXR, "fto_exec");
        cyc(1'b0, OP_R, 4'd10, W_AWB, "fto_wb");

        // MEM_RD timeout returns to FETCH without mdr_we
        cyc(1'b1, OP_LD, 4'd1, W_FR, "rto_fetch");
        cyc(1'b0, OP_LD, 4'd2, W_DEC, "rto_dec");
        cyc(1'b0, OP_LD, 4'd5, W_MAL, "rto_addr");
        cyc(1'b0, OP_LD, 4'd6, W_RDW, "rto_w0");
        cyc(1'b0, OP_LD, 4'd6, W_RDW, "rto_w1");
        cyc(1'b0, OP_LD, 4'd6, W_RDW, "rto_w2");
        cyc(1'b0, OP_LD, 4'd6, W_RDW | BERR, "rto_err");

        // MEM_WR completes on the last allowed cycle
        cyc(1'b1, OP_ST, 4'd1, W_FR, "wto_fetch");
        cyc(1'b0, OP_ST, 4'd2, W_DEC, "wto_dec");
        cyc(1'b0, OP_ST, 4'd5, W_MAS, "wto_addr");
        cyc(1'b0, OP_ST, 4'd8, W_WRW, "wto_w0");
        cyc(1'b0, OP_ST, 4'd8, W_WRW, "wto_w1");
        cyc(1'b0, OP_ST, 4'd8, W_WRW, "wto_w2");
        cyc(1'b1, OP_ST, 4'd8, W_WRW, "wto_rdy");

        // Reset in the middle of MEM_RD
        cyc(1'b1, OP_LD, 4'd1, W_FR, "mr_fetch");
        cyc(1'b0, OP_LD, 4'd2, W_DEC, "mr_dec");
        cyc(1'b0, OP_LD, 4'd5, W_MAL, "mr_addr");
        cyc(1'b0, OP_LD, 4'd6, W_RDW, "mr_rd0");
        rst_n = 1'b0;
        cyc(1'b0, OP_LD, 4'd6, W_RDW, "mr_rd1");
        rst_n = 1'b1;
        cyc(1'b0, OP_LD, 4'd0, W_IDLE, "mr_idle");
        cyc(1'b1, OP_LD, 4'd1, W_FR, "mr_refetch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
